// File: rtl/mem_stage_pkg.sv
// Shared widths, opcodes and FSM encoding for the MEM pipeline stage.
// Opcode classification helpers are used by the stage and by the align logic.
package mem_stage_pkg;

    localparam int unsigned RegBus     = 32;
    localparam int unsigned RegAddrBus = 5;

    localparam logic RstEnable = 1'b1;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    localparam logic [7:0] EXE_LB_OP  = 8'hE0;
    localparam logic [7:0] EXE_LBU_OP = 8'hE4;
    localparam logic [7:0] EXE_LH_OP  = 8'hE1;
    localparam logic [7:0] EXE_LHU_OP = 8'hE5;
    localparam logic [7:0] EXE_LW_OP  = 8'hE3;
    localparam logic [7:0] EXE_LL_OP  = 8'hF0;
    localparam logic [7:0] EXE_SB_OP  = 8'hE8;
    localparam logic [7:0] EXE_SH_OP  = 8'hE9;
    localparam logic [7:0] EXE_SW_OP  = 8'hEB;
    localparam logic [7:0] EXE_SC_OP  = 8'hF8;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_BUSY = 2'b01,
        MEM_DONE = 2'b10
    } mem_state_e;

    function automatic logic is_load(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP,
            EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge data bus between the MEM stage (master) and memory (slave).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              req;
    logic              we;
    logic [RegBus-1:0] addr;
    logic [3:0]        sel;
    logic [RegBus-1:0] wdata;
    logic [RegBus-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, sel, wdata, input rdata, ack);
    modport slave  (input req, we, addr, sel, wdata, output rdata, ack);

endinterface

// File: rtl/mem_stage_align.sv
// Big-endian byte-lane logic: store byte enables/data replication and
// load lane extraction with sign or zero extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [7:0]        aluop,
    input  logic [1:0]        addr_lo,
    input  logic [RegBus-1:0] reg2,
    input  logic [RegBus-1:0] rdata,
    output logic [3:0]        sel,
    output logic [RegBus-1:0] wdata,
    output logic [RegBus-1:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        case (addr_lo)
            2'b00:   lane_byte = rdata[31:24];
            2'b01:   lane_byte = rdata[23:16];
            2'b10:   lane_byte = rdata[15:8];
            default: lane_byte = rdata[7:0];
        endcase
        lane_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        sel       = '0;
        wdata     = reg2;
        load_data = '0;
        case (aluop)
            EXE_LB_OP: begin
                sel       = 4'b1000 >> addr_lo;
                load_data = {{24{lane_byte[7]}}, lane_byte};
            end
            EXE_LBU_OP: begin
                sel       = 4'b1000 >> addr_lo;
                load_data = {24'h000000, lane_byte};
            end
            EXE_LH_OP: begin
                sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
                load_data = {{16{lane_half[15]}}, lane_half};
            end
            EXE_LHU_OP: begin
                sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
                load_data = {16'h0000, lane_half};
            end
            EXE_LW_OP, EXE_LL_OP: begin
                sel       = '1;
                load_data = rdata;
            end
            EXE_SB_OP: begin
                sel   = 4'b1000 >> addr_lo;
                wdata = {4{reg2[7:0]}};
            end
            EXE_SH_OP: begin
                sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata = {2{reg2[15:0]}};
            end
            EXE_SW_OP, EXE_SC_OP: sel = '1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on the data bus, stalls until ack,
// resolves LL/SC link bit, and passes non-memory instructions straight through.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [RegBus-1:0]     wdata_i,
    input  logic [RegBus-1:0]     hi_i,
    input  logic [RegBus-1:0]     lo_i,
    input  logic                  whilo_i,
    input  logic [7:0]            aluop_i,
    input  logic [RegBus-1:0]     mem_addr_i,
    input  logic [RegBus-1:0]     reg2_i,
    input  logic [5:0]            stall,
    input  logic                  LLbit_i,
    input  logic                  wb_LLbit_we,
    input  logic                  wb_LLbit_value,

    mem_stage_if.master           dbus,

    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o,
    output logic [RegBus-1:0]     hi_o,
    output logic [RegBus-1:0]     lo_o,
    output logic                  whilo_o,
    output logic                  LLbit_we_o,
    output logic                  LLbit_value_o,
    output logic                  stallreq
);

    mem_state_e        state, state_next;
    logic [RegBus-1:0] cap_data;
    logic [RegBus-1:0] hold_addr, hold_wdata;
    logic [3:0]        hold_sel;
    logic              hold_we;

    logic [RegBus-1:0] word_addr, align_wdata, align_load;
    logic [3:0]        align_sel;
    logic              llbit_eff, ld, st, is_ll, is_sc, bus_op;
    logic              unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};

    assign word_addr = {mem_addr_i[31:2], 2'b00};
    assign llbit_eff = wb_LLbit_we ? wb_LLbit_value : LLbit_i;
    assign ld        = is_load(aluop_i);
    assign st        = is_store(aluop_i);
    assign is_ll     = (aluop_i == EXE_LL_OP);
    assign is_sc     = (aluop_i == EXE_SC_OP);
    // A failed SC never touches the bus; every other load/store does.
    assign bus_op    = ld | (st & ~is_sc) | (is_sc & llbit_eff);

    mem_align u_align (
        .aluop     (aluop_i),
        .addr_lo   (mem_addr_i[1:0]),
        .reg2      (reg2_i),
        .rdata     (dbus.rdata),
        .sel       (align_sel),
        .wdata     (align_wdata),
        .load_data (align_load)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state      <= MEM_IDLE;
            cap_data   <= '0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_sel   <= '0;
            hold_we    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == MEM_IDLE && bus_op) begin
                hold_addr  <= word_addr;
                hold_wdata <= align_wdata;
                hold_sel   <= align_sel;
                hold_we    <= st;
            end
            if (dbus.ack && ((state == MEM_IDLE && bus_op) || state == MEM_BUSY))
                cap_data <= align_load;
        end
    end

    always_comb begin
        state_next    = state;
        dbus.req      = 1'b0;
        dbus.we       = 1'b0;
        dbus.addr     = word_addr;
        dbus.sel      = align_sel;
        dbus.wdata    = align_wdata;
        stallreq      = 1'b0;
        wd_o          = wd_i;
        wreg_o        = wreg_i;
        wdata_o       = wdata_i;
        hi_o          = hi_i;
        lo_o          = lo_i;
        whilo_o       = whilo_i;
        LLbit_we_o    = 1'b0;
        LLbit_value_o = 1'b0;

        case (state)
            MEM_IDLE: begin
                if (bus_op) begin
                    dbus.req   = 1'b1;
                    dbus.we    = st;
                    stallreq   = 1'b1;
                    wreg_o     = 1'b0;
                    whilo_o    = 1'b0;
                    state_next = dbus.ack ? MEM_DONE : MEM_BUSY;
                end else if (is_sc) begin
                    wdata_o = '0;
                end
            end
            MEM_BUSY: begin
                dbus.req   = 1'b1;
                dbus.we    = hold_we;
                dbus.addr  = hold_addr;
                dbus.sel   = hold_sel;
                dbus.wdata = hold_wdata;
                stallreq   = 1'b1;
                wreg_o     = 1'b0;
                whilo_o    = 1'b0;
                if (dbus.ack) state_next = MEM_DONE;
            end
            MEM_DONE: begin
                if (ld) wdata_o = cap_data;
                if (is_ll) begin
                    LLbit_we_o    = 1'b1;
                    LLbit_value_o = 1'b1;
                end
                // Reaching DONE with an SC means the link bit was set at issue.
                if (is_sc) begin
                    wdata_o       = 32'h0000_0001;
                    LLbit_we_o    = 1'b1;
                    LLbit_value_o = 1'b0;
                end
                if (stall[4] == NoStop) state_next = MEM_IDLE;
                else if (stall[4] == Stop) state_next = MEM_DONE;
            end
            default: state_next = MEM_IDLE;
        endcase

        if (rst == RstEnable) begin
            dbus.req      = 1'b0;
            dbus.we       = 1'b0;
            dbus.addr     = '0;
            dbus.sel      = '0;
            dbus.wdata    = '0;
            stallreq      = 1'b0;
            wd_o          = '0;
            wreg_o        = 1'b0;
            wdata_o       = '0;
            hi_o          = '0;
            lo_o          = '0;
            whilo_o       = 1'b0;
            LLbit_we_o    = 1'b0;
            LLbit_value_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage with a behavioural
// reference model of byte lanes, extension and LL/SC outcomes.
module tb_mem_stage;

    localparam logic [7:0] OP_LB = 8'hE0, OP_LBU = 8'hE4, OP_LH = 8'hE1, OP_LHU = 8'hE5;
    localparam logic [7:0] OP_LW = 8'hE3, OP_LL  = 8'hF0, OP_SB = 8'hE8, OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW = 8'hEB, OP_SC  = 8'hF8, OP_ADDU = 8'h21;

    logic        clk, rst;
    logic [4:0]  wd_i, wd_o;
    logic        wreg_i, wreg_o, whilo_i, whilo_o;
    logic [31:0] wdata_i, wdata_o, hi_i, hi_o, lo_i, lo_o, mem_addr_i, reg2_i;
    logic [7:0]  aluop_i;
    logic [5:0]  stall;
    logic        LLbit_i, wb_LLbit_we, wb_LLbit_value, LLbit_we_o, LLbit_value_o, stallreq;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_stage_if dbus();

    mem_stage dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .stall(stall), .LLbit_i(LLbit_i),
        .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
        .dbus(dbus),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
        .LLbit_we_o(LLbit_we_o), .LLbit_value_o(LLbit_value_o),
        .stallreq(stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [175:0] all_out;
    assign all_out = {wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, LLbit_we_o, LLbit_value_o,
                      dbus.req, dbus.we, dbus.addr, dbus.sel, dbus.wdata, stallreq};

    // ---------------- reference model ----------------
    function automatic bit m_is_load(input logic [7:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL};
    endfunction

    function automatic bit m_is_store(input logic [7:0] op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SC};
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] addr);
        int unsigned lane = addr % 4;
        if (op inside {OP_LB, OP_LBU, OP_SB}) return 4'(1 << (3 - lane));
        if (op inside {OP_LH, OP_LHU, OP_SH}) return (lane >= 2) ? 4'd3 : 4'd12;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_store(input logic [7:0] op, input logic [31:0] r2);
        if (op == OP_SB) return (r2 & 32'hFF) * 32'h0101_0101;
        if (op == OP_SH) return (r2 & 32'hFFFF) * 32'h0001_0001;
        return r2;
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
        int unsigned lane = addr % 4;
        logic [31:0] b, h;
        b = (rd >> (8 * (3 - lane))) & 32'hFF;
        h = (lane >= 2) ? (rd & 32'hFFFF) : (rd >> 16);
        case (op)
            OP_LB:   return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            OP_LHU:  return h;
            default: return rd;
        endcase
    endfunction

    // Issue one memory instruction and follow it through stall and DONE cycles.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                           input logic [31:0] rd, input int unsigned waits,
                           input bit llb, input bit wbwe, input bit wbval, input bit hold,
                           input string tag);
        bit link = wbwe ? wbval : llb;
        bit sc   = (op == OP_SC);
        bit bus  = !(sc && !link);
        logic [31:0] wdi = $urandom, hii = $urandom, loi = $urandom;
        logic [4:0]  wdv = 5'($urandom);
        logic [31:0] exp_wdata;
        logic [43:0] got_s, exp_s;
        logic [71:0] got_d, exp_d;
        int unsigned n_done;
        @(negedge clk);
        aluop_i = op; mem_addr_i = addr; reg2_i = r2; wdata_i = wdi; wd_i = wdv;
        wreg_i = 1'b1; whilo_i = 1'b1; hi_i = hii; lo_i = loi;
        LLbit_i = llb; wb_LLbit_we = wbwe; wb_LLbit_value = wbval;
        stall = '0; dbus.ack = 1'b0; dbus.rdata = $urandom;
        if (!bus) begin
            #1;
            checks++;
            if ({dbus.req, stallreq, wdata_o, LLbit_we_o, wreg_o} !== {2'b00, 32'h0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL %s sc_fail: got req=%b stallreq=%b wdata=%h llwe=%b wreg=%b exp req=0 stallreq=0 wdata=0 llwe=0 wreg=1",
                         tag, dbus.req, stallreq, wdata_o, LLbit_we_o, wreg_o);
            end
            return;
        end
        for (int k = 0; k <= int'(waits); k++) begin
            if (k > 0) @(negedge clk);
            dbus.ack   = (k == int'(waits));
            dbus.rdata = (k == int'(waits)) ? rd : $urandom;
            stall[4]   = hold;
            #1;
            got_s = {stallreq, dbus.req, dbus.we, dbus.addr, dbus.sel, wreg_o, whilo_o, LLbit_we_o, 3'b000};
            exp_s = {1'b1, 1'b1, 1'(m_is_store(op)), addr & 32'hFFFF_FFFC, m_sel(op, addr), 3'b000, 3'b000};
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL %s stall_cycle%0d: got %h exp %h (stallreq,req,we,addr,sel,wreg,whilo,llwe)",
                         tag, k, got_s, exp_s);
            end
            if (m_is_store(op)) begin
                checks++;
                if (dbus.wdata !== m_store(op, r2)) begin
                    errors++;
                    $display("FAIL %s store_data: got %h exp %h", tag, dbus.wdata, m_store(op, r2));
                end
            end
        end
        exp_wdata = m_is_load(op) ? m_load(op, addr, rd) : (sc ? 32'h1 : wdi);
        n_done = hold ? 3 : 1;
        @(negedge clk);
        dbus.ack = 1'b0; dbus.rdata = $urandom;
        for (int d = 0; d < int'(n_done); d++) begin
            if (d > 0) @(negedge clk);
            stall[4] = (d < int'(n_done) - 1);
            #1;
            got_d = {stallreq, dbus.req, wreg_o, whilo_o, LLbit_we_o, LLbit_value_o, wd_o, 1'b0, wdata_o, hi_o[23:0]};
            exp_d = {1'b0, 1'b0, 1'b1, 1'b1, 1'(op == OP_LL || sc), 1'(op == OP_LL), wdv, 1'b0, exp_wdata, hii[23:0]};
            checks++;
            if (got_d !== exp_d) begin
                errors++;
                $display("FAIL %s done%0d: got %h exp %h (stallreq,req,wreg,whilo,llwe,llval,wd,wdata,hi)",
                         tag, d, got_d, exp_d);
            end
        end
    endtask

    task automatic set_nop(input logic [31:0] val);
        aluop_i = OP_ADDU; wdata_i = val; wd_i = 5'd3; wreg_i = 1'b1; whilo_i = 1'b0;
        hi_i = '0; lo_i = '0; mem_addr_i = $urandom; reg2_i = $urandom;
        LLbit_i = 1'b0; wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; stall = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        aluop_i = OP_LW; mem_addr_i = 32'h0000_1004; reg2_i = $urandom; wdata_i = $urandom;
        wd_i = 5'd7; wreg_i = 1'b1; whilo_i = 1'b1; hi_i = $urandom; lo_i = $urandom;
        LLbit_i = 1'b1; wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; stall = '0;
        dbus.ack = 1'b1; dbus.rdata = $urandom;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (all_out !== '0) begin
                errors++;
                $display("FAIL reset_outputs%0d: got %h exp 0", i, all_out);
            end
        end
        @(negedge clk);
        rst = 1'b0; dbus.ack = 1'b0;
        set_nop(32'h0000_5A5A);
        #1;
        checks++;
        if ({stallreq, dbus.req, wdata_o} !== {2'b00, 32'h0000_5A5A}) begin
            errors++;
            $display("FAIL reset_release: got stallreq=%b req=%b wdata=%h exp 0 0 00005a5a",
                     stallreq, dbus.req, wdata_o);
        end
    endtask

    task automatic test_passthrough();
        logic [7:0]  op;
        logic [31:0] wv, hv, lv;
        logic [4:0]  wdv;
        logic        wr, whl;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            op = 8'($urandom_range(0, 255));
            if (i == 0 || m_is_load(op) || m_is_store(op)) op = OP_ADDU;
            wv  = (i == 0) ? 32'h0000_1234 : $urandom;
            wdv = (i == 0) ? 5'd3 : 5'($urandom);
            wr  = (i == 0) ? 1'b1 : 1'($urandom);
            whl = 1'($urandom); hv = $urandom; lv = $urandom;
            aluop_i = op; wdata_i = wv; wd_i = wdv; wreg_i = wr; whilo_i = whl; hi_i = hv; lo_i = lv;
            mem_addr_i = $urandom; reg2_i = $urandom; LLbit_i = 1'($urandom);
            wb_LLbit_we = 1'($urandom); wb_LLbit_value = 1'($urandom); stall = '0;
            dbus.ack = 1'($urandom); dbus.rdata = $urandom;
            #1;
            checks++;
            if ({wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, LLbit_we_o, dbus.req, stallreq} !==
                {wdv, wr, wv, hv, lv, whl, 3'b000}) begin
                errors++;
                $display("FAIL passthrough%0d op=%h: got wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b llwe=%b req=%b stallreq=%b exp wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b 0 0 0",
                         i, op, wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, LLbit_we_o, dbus.req, stallreq,
                         wdv, wr, wv, hv, lv, whl);
            end
        end
        dbus.ack = 1'b0;
    endtask

    task automatic test_directed();
        run_mem(OP_LB,  32'h0000_1001, 32'h0,          32'h0080_FF00, 0, 1'b0, 1'b0, 1'b0, 1'b0, "lb_0wait");
        run_mem(OP_LHU, 32'h0000_2002, 32'h0,          32'hAAAA_8001, 3, 1'b0, 1'b0, 1'b0, 1'b0, "lhu_3wait");
        run_mem(OP_SB,  32'h0000_3003, 32'h0000_0055,  32'h0,         0, 1'b0, 1'b0, 1'b0, 1'b0, "sb_lane3");
        run_mem(OP_SH,  32'h0000_3001, 32'hDEAD_BEEF,  32'h0,         1, 1'b0, 1'b0, 1'b0, 1'b0, "sh_odd");
        run_mem(OP_LH,  32'h0000_4000, 32'h0,          32'h8123_4567, 2, 1'b0, 1'b0, 1'b0, 1'b0, "lh_neg");
        run_mem(OP_LW,  32'h0000_4003, 32'h0,          32'hCAFE_F00D, 0, 1'b0, 1'b0, 1'b0, 1'b0, "lw_unaligned");
    endtask

    task automatic test_llsc();
        run_mem(OP_LL, 32'h0000_5000, 32'h0,         32'h1357_9BDF, 1, 1'b0, 1'b0, 1'b0, 1'b0, "ll");
        run_mem(OP_SC, 32'h0000_5000, 32'h0BAD_CAFE, 32'h0,         0, 1'b0, 1'b1, 1'b1, 1'b0, "sc_fwd_set");
        run_mem(OP_SC, 32'h0000_5000, 32'h0BAD_CAFE, 32'h0,         0, 1'b1, 1'b1, 1'b0, 1'b0, "sc_fwd_clr");
        run_mem(OP_SC, 32'h0000_5000, 32'h1111_2222, 32'h0,         0, 1'b0, 1'b0, 1'b0, 1'b0, "sc_link0");
        run_mem(OP_SC, 32'h0000_5004, 32'h3333_4444, 32'h0,         2, 1'b1, 1'b0, 1'b0, 1'b0, "sc_link1");
    endtask

    task automatic test_stall_in_done();
        run_mem(OP_LW, 32'h0000_6008, 32'h0, 32'h89AB_CDEF, 1, 1'b0, 1'b0, 1'b0, 1'b1, "hold_lw");
        run_mem(OP_LB, 32'h0000_6002, 32'h0, 32'h0000_7F00, 0, 1'b0, 1'b0, 1'b0, 1'b1, "hold_lb_ack");
    endtask

    task automatic test_random();
        logic [7:0] ops [10] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_SB, OP_SH, OP_SW, OP_SC};
        for (int i = 0; i < 40; i++) begin
            run_mem(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom, $urandom_range(0, 3),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0), "random");
        end
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        aluop_i = OP_LW; mem_addr_i = 32'h0000_7000; wd_i = 5'd9; wreg_i = 1'b1; whilo_i = 1'b0;
        LLbit_i = 1'b0; wb_LLbit_we = 1'b0; stall = '0; dbus.ack = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({dbus.req, stallreq} !== 2'b11) begin
            errors++;
            $display("FAIL busy_before_reset: got req=%b stallreq=%b exp 1 1", dbus.req, stallreq);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_in_busy: got %h exp 0", all_out);
        end
        @(negedge clk);
        rst = 1'b0;
        set_nop(32'h0000_ABCD);
        dbus.ack = 1'b1; dbus.rdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({dbus.req, stallreq, wdata_o} !== {2'b00, 32'h0000_ABCD}) begin
            errors++;
            $display("FAIL after_reset_idle: got req=%b stallreq=%b wdata=%h exp 0 0 0000abcd",
                     dbus.req, stallreq, wdata_o);
        end
        @(negedge clk);
        dbus.ack = 1'b0;
        #1;
        checks++;
        if ({dbus.req, stallreq, wdata_o} !== {2'b00, 32'h0000_ABCD}) begin
            errors++;
            $display("FAIL late_ack_ignored: got req=%b stallreq=%b wdata=%h exp 0 0 0000abcd",
                     dbus.req, stallreq, wdata_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        dbus.ack = 1'b0;
        dbus.rdata = '0;
        set_nop(32'h0);
        test_reset();
        test_passthrough();
        test_directed();
        test_llsc();
        test_stall_in_done();
        test_random();
        test_reset_busy();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the EX/MEM register and the MEM/WB register. It issues load and store transactions on a req/ack data bus and raises a stall request until the access completes. It performs byte-lane selection, load extraction and extension, and LL/SC link-bit resolution. Non-memory instructions pass through with zero added latency.

## Interface
- No parameters. Widths come from `RegBus` (32) and `RegAddrBus` (5) in the shared defines.
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset (`RstEnable`).
- wd_i, wreg_i, wdata_i  in  5/1/32  destination address, write enable and ALU result from EX/MEM.
- hi_i, lo_i, whilo_i  in  32/32/1  HI/LO result, passed through unchanged.
- aluop_i  in  8  operation code.
- mem_addr_i  in  32  effective address.
- reg2_i  in  32  store data.
- stall  in  6  pipeline stall vector. stall[4]=1 means the instruction in MEM does not advance this cycle.
- LLbit_i  in  1  committed link bit.
- wb_LLbit_we, wb_LLbit_value  in  1/1  link-bit write in flight at WB, used for forwarding.
- dbus_rdata  in  32  read data; valid in the cycle dbus_ack=1.
- dbus_ack  in  1  transaction complete.
- dbus_req, dbus_we  out  1/1  request and write enable.
- dbus_addr  out  32  word address: {mem_addr_i[31:2],2'b00}.
- dbus_sel  out  4  byte enables. Bit 3 is bits 31:24.
- dbus_wdata  out  32  store data, replicated across lanes.
- wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o  out  to MEM/WB.
- LLbit_we_o, LLbit_value_o  out  1/1  to MEM/WB.
- stallreq  out  1  request to the stall controller.

## Operation
Opcodes, all in defines.v:
- Loads: LB E0, LBU E4, LH E1, LHU E5, LW E3, LL F0.
- Stores: SB E8, SH E9, SW EB, SC F8.
- Any other opcode is a pass-through.

Byte lanes are big-endian.
- Byte access: sel is one-hot; addr[1:0]=00 → 1000, 11 → 0001.
- Halfword access: addr[1]=0 → 1100, 1 → 0011. addr[0] is ignored.
- Word access: sel=1111. addr[1:0] is ignored. No alignment exceptions are raised in this stage.

Load data:
- The selected lane is sign-extended for LB/LH and zero-extended for LBU/LHU.
- The result goes to wdata_o. wreg_o is taken from wreg_i.

Store data:
- SB replicates reg2_i[7:0] across all four lanes.
- SH replicates reg2_i[15:0] across both halves.
- SW/SC drive reg2_i unchanged.

Link bit: effective LLbit = wb_LLbit_we ? wb_LLbit_value : LLbit_i.
- LL: word load; LLbit_we_o=1, LLbit_value_o=1.
- SC with LLbit=1: word store; wdata_o=1, LLbit_we_o=1, LLbit_value_o=0.
- SC with LLbit=0: no bus access and no stall; wdata_o=0, LLbit_we_o=0.

FSM states are IDLE, BUSY and DONE.
- IDLE with a bus operation present: dbus_req=1, stallreq=1.
  - ack=1 → capture rdata, go to DONE.
  - ack=0 → go to BUSY.
- BUSY: dbus_req=1, stallreq=1. Address, sel and data are held. ack=1 → capture, go to DONE.
- DONE: dbus_req=0, stallreq=0. Outputs come from the captured data.
  - stall[4]=0 → go to IDLE.
  - stall[4]=1 → stay in DONE. The access is not reissued.
- Pass-through instructions and failed SC stay in IDLE with dbus_req=0 and stallreq=0.

## Timing
- Pass-through: outputs are combinational from the inputs, with 0 added cycles.
- Bus operation: N ≥ 0 wait cycles before ack. stallreq is high for N+1 cycles, and the result is presented in DONE, the cycle after ack.
- The minimum memory-op occupancy of MEM is 2 cycles.
- While stallreq=1, wreg_o=0, whilo_o=0 and LLbit_we_o=0. No partial results are committed.
- Reset asserted on a clock edge forces state to IDLE and the captured data to 0.
  - A late ack after reset is ignored.
  - While rst=1, every output is 0: wd_o, wdata_o, hi_o, lo_o, dbus_addr, dbus_sel, dbus_wdata, plus all enables, dbus_req and stallreq.
- Simultaneous events:
  - ack in the same cycle as stall[4]=1: capture anyway and enter DONE.
  - WB link-bit forwarding takes priority over LLbit_i in the same cycle.

## Structure
- Opcode constants, the state encoding (2 bits) and `Stop`/`NoStop` go in defines.v.
- Sub-module mem_align (combinational) holds the load lane extract/extend and the store sel/wdata generation. The top level holds the FSM, capture register and link-bit logic.

## Test plan
- ADDU result 0x1234, wd=3: same-cycle wdata_o=0x1234, wreg_o=1, stallreq=0, dbus_req=0.
- LB at addr 0x1001 with rdata 0x0080FF00, ack 0-wait:
  - sel=0100, stallreq high for 1 cycle.
  - Next cycle wdata_o=0xFFFFFF80.
- LHU at 0x2002 with rdata 0xAAAA8001, ack after 3 waits: stallreq high for 4 cycles, then wdata_o=0x00008001.
- SB reg2=0x55 at 0x3003: dbus_we=1, sel=0001, wdata=0x55555555.
- LL followed by SC with wb_LLbit_we=1, value=1 and LLbit_i=0: SC issues a store; wdata_o=1, LLbit_we_o=1, value=0.
- SC with LLbit=0: no dbus_req, wdata_o=0. Separately, reset during BUSY: next cycle dbus_req=0 and state IDLE.
